// File: rtl/hps_rom_loader.sv
// ---------------------------------------------------------------------------
// hps_rom_loader
//   Bridge between the hps_io ioctl download port and the PC88 core LOADER_*
//   port. A ROM download (ioctl_index == ROM_INDEX) is filtered by address,
//   buffered in a small FIFO, and replayed into the core as a single-
//   outstanding write/ack handshake. A sticky done flag is raised once the
//   download has ended and every buffered byte has been accepted.
//
// Ports
//   clk_sys         system clock
//   reset           asynchronous, active-high reset
//   ioctl_download  download in progress (hps_io)
//   ioctl_index     download target index
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address (25 bits)
//   ioctl_dout      byte data
//   ioctl_wait      stall request back to hps_io
//   ldr_oe          loader owns core memory (LOAD and DRAIN)
//   ldr_adr         write address to core
//   ldr_wdat        write data to core
//   ldr_wr          write request level, held until acknowledged
//   ldr_ack         core acknowledge (rising edge accepts the write)
//   ldr_done        sticky: download complete and drained
//   ldr_err         sticky: a byte was dropped (overflow or address range)
// ---------------------------------------------------------------------------
module hps_rom_loader #(
  parameter int         ADDR_W    = 19,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] ROM_INDEX = 8'd0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              ldr_oe,
  output logic [ADDR_W-1:0] ldr_adr,
  output logic [7:0]        ldr_wdat,
  output logic              ldr_wr,
  input  logic              ldr_ack,
  output logic              ldr_done,
  output logic              ldr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 8;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              old_dl_q;
  logic              old_ack_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic              err_q, err_d;
  logic [EW-1:0]     mem_q [DEPTH];

  logic          dl_rise, dl_fall;
  logic          in_range, full, empty;
  logic          push_req, push, pop, issue;
  logic [EW-1:0] head;

  assign dl_rise  = ioctl_download & ~old_dl_q;
  assign dl_fall  = ~ioctl_download & old_dl_q;
  assign in_range = ((ioctl_addr >> ADDR_W) == 25'd0);
  assign full     = (count_q == FULL_LVL);
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];

  // Bytes are only taken while loading. A full FIFO still accepts a byte
  // when the head is popped on the same edge, since a slot frees up.
  assign push_req = (state_q == S_LOAD) & ioctl_wr;
  assign push     = push_req & in_range & (~full | pop);

  // Acceptance is the registered rising edge of ack while a write is pending.
  assign pop   = wr_q & ldr_ack & ~old_ack_q;
  // A new write waits until ack has been observed low again.
  assign issue = ~wr_q & ~empty & ~old_ack_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dl_rise && (ioctl_index == ROM_INDEX)) state_d = S_LOAD;
      S_LOAD:  if (dl_fall) state_d = S_DRAIN;
      S_DRAIN: if (empty && !wr_q) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wr_d   = wr_q;
    adr_d  = adr_q;
    wdat_d = wdat_q;
    if (pop) begin
      wr_d = 1'b0;
    end else if (issue) begin
      wr_d   = 1'b1;
      adr_d  = head[EW-1:8];
      wdat_d = head[7:0];
    end
  end

  assign err_d = err_q | (push_req & ~push);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      old_dl_q  <= 1'b0;
      // Starting high means an ack held across reset is not seen as an edge.
      old_ack_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_q      <= 1'b0;
      adr_q     <= '0;
      wdat_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      old_dl_q  <= ioctl_download;
      old_ack_q <= ldr_ack;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_q      <= wr_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      err_q     <= err_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
  end

  // Wait asserts one entry early to absorb the strobe already in flight.
  assign ioctl_wait = (state_q == S_LOAD) && (count_q >= WAIT_LVL);
  assign ldr_oe     = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign ldr_done   = (state_q == S_DONE);
  assign ldr_adr    = adr_q;
  assign ldr_wdat   = wdat_q;
  assign ldr_wr     = wr_q;
  assign ldr_err    = err_q;

endmodule
